// File: rtl/arb_pkg.sv
// Shared definitions for the register write arbiter: FSM state encoding and default sizes.
package arb_pkg;
    localparam int N_REQ_DEF = 4;
    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        LOCKED = 2'd2
    } arb_state_t;
endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: the first set request at or above ptr, wrapping to 0.
import arb_pkg::*;

module rr_priority_pick #(
    parameter int N_REQ = N_REQ_DEF,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [PW-1:0]    winner,
    output logic             any_valid
);
    logic [N_REQ-1:0] at_or_above;
    logic             hi_found;
    logic [PW-1:0]    hi_idx;
    logic [PW-1:0]    lo_idx;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
        assign at_or_above[gi] = (PW'(gi) >= ptr);
    end

    // Scanning downward leaves the lowest matching index in each candidate.
    always_comb begin
        hi_found  = 1'b0;
        hi_idx    = '0;
        lo_idx    = '0;
        any_valid = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                any_valid = 1'b1;
                lo_idx    = PW'(i);
                if (at_or_above[i]) begin
                    hi_found = 1'b1;
                    hi_idx   = PW'(i);
                end
            end
        end
        winner = hi_found ? hi_idx : lo_idx;
    end
endmodule

// File: rtl/register_write_arbiter.sv
// Round-robin arbiter writing one requester's data into a shared register per edge.
// Define ARB_LOCK_EN to add the Lock port and the LOCKED burst state.
import arb_pkg::*;

module register_write_arbiter #(
    parameter int N_REQ = N_REQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [N_REQ-1:0]       Req,
    input  logic [N_REQ*WIDTH-1:0] Data_In,
`ifdef ARB_LOCK_EN
    input  logic [N_REQ-1:0]       Lock,
`endif
    output logic [N_REQ-1:0]       Grant,
    output logic [WIDTH-1:0]       Data_Out,
    output logic [PW-1:0]          Owner,
    output logic                   Valid
);
    arb_state_t       state_reg;
    logic [PW-1:0]    ptr_reg;
    logic [PW-1:0]    ptr_next;
    logic [N_REQ-1:0] eff_req;
    logic [PW-1:0]    pick_winner;
    logic             pick_valid;
    logic             wr_en;
    logic [PW-1:0]    wr_idx;
    logic [N_REQ-1:0] wr_onehot;
    logic [WIDTH-1:0] data_arr [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign data_arr[gi] = Data_In[gi*WIDTH +: WIDTH];
    end

    // Masking with the current grant stops a held request from winning twice in a row.
    assign eff_req = Req & ~Grant;

    rr_priority_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
        .req       (eff_req),
        .ptr       (ptr_reg),
        .winner    (pick_winner),
        .any_valid (pick_valid)
    );

    assign ptr_next  = (pick_winner == PW'(N_REQ - 1)) ? '0 : pick_winner + PW'(1);
    assign wr_onehot = N_REQ'(1) << wr_idx;

    always_comb begin
        wr_idx = pick_winner;
        wr_en  = pick_valid;
`ifdef ARB_LOCK_EN
        if (state_reg == LOCKED) begin
            wr_idx = Owner;
            wr_en  = Lock[Owner] & Req[Owner];
        end
`endif
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            Grant     <= '0;
            Owner     <= '0;
            Valid     <= 1'b0;
        end else begin
            Grant <= wr_en ? wr_onehot : '0;
            Valid <= wr_en;
            if (wr_en) begin
                Owner <= wr_idx;
            end
            case (state_reg)
                IDLE, GRANT: begin
                    if (pick_valid) begin
                        ptr_reg <= ptr_next;
`ifdef ARB_LOCK_EN
                        state_reg <= Lock[pick_winner] ? LOCKED : GRANT;
`else
                        state_reg <= GRANT;
`endif
                    end else begin
                        state_reg <= IDLE;
                    end
                end
`ifdef ARB_LOCK_EN
                // Ptr already points past the owner from the entry edge.
                LOCKED: begin
                    if (!Lock[Owner]) begin
                        state_reg <= IDLE;
                    end
                end
`endif
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Shared storage register, enabled by the write decision.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Data_Out <= '0;
        end else if (wr_en) begin
            Data_Out <= data_arr[wr_idx];
        end
    end
endmodule

// File: doc/register_write_arbiter.md
REGISTER_WRITE_ARBITER -- requirements
Module: register_write_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters, 2..8.
REQ-002 Parameter WIDTH, default 32: data width of the shared register.
REQ-003 Clock  input  1  rising-edge clock.
REQ-004 Reset  input  1  reset, asynchronous, active-low.
REQ-005 Req  input  N_REQ  per-requester write request.
REQ-006 Data_In  input  N_REQ*WIDTH  flattened write data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Lock  input  N_REQ  per-requester burst-lock request; port exists only with ARB_LOCK_EN.
REQ-008 Grant  output  N_REQ  registered one-hot write acknowledge.
REQ-009 Data_Out  output  WIDTH  shared register contents.
REQ-010 Owner  output  clog2(N_REQ)  index of the requester of the last write.
REQ-011 Valid  output  1  high for each cycle following a write to Data_Out.

Function
REQ-012 Effective request = Req & ~Grant, so a grant consumes the request sampled at its edge.
REQ-013 Winner = first effective request at or above rotating pointer Ptr, searching upward with wrap from N_REQ-1 to 0.
REQ-014 At an edge with a winner: Data_Out <= Data_In[winner]; Grant <= onehot(winner); Owner <= winner; Valid <= 1; Ptr <= (winner+1) mod N_REQ.
REQ-015 At an edge with no winner: Grant <= 0; Valid <= 0; Data_Out, Owner, and Ptr hold.
REQ-016 Latency is one edge from sampled Req to Grant, Data_Out, and Valid.
REQ-017 A requester holding Req continuously is granted at most every second cycle; other pending requesters are served in between by rotation.
REQ-018 FSM states: IDLE (Grant=0), GRANT (single-cycle grant), LOCKED (burst, ARB_LOCK_EN only).
REQ-019 IDLE/GRANT -> GRANT on a winner; -> IDLE with no winner; -> LOCKED on a winner whose Lock bit is high.
REQ-020 With N_REQ not a power of two, Ptr wraps to 0 after N_REQ-1 and never holds an invalid index.

Reset
REQ-021 Reset low immediately forces Data_Out=0, Grant=0, Owner=0, Valid=0, Ptr=0, and state IDLE, independent of Clock.
REQ-022 Reset mid-burst or mid-grant discards the grant; the first write after Reset rises uses Ptr=0.

Configuration
REQ-023 Macro ARB_LOCK_EN, when defined, adds the Lock port and the LOCKED state.
REQ-024 In LOCKED, only Owner is eligible, and the REQ-012 mask is not applied to Owner.
REQ-025 In LOCKED, each edge with Req[Owner] high writes Data_In[Owner] with Grant and Valid high; Req[Owner] low holds Data_Out with Grant=0.
REQ-026 LOCKED exits to IDLE at the first edge where Lock[Owner] is low; no write occurs at that edge; Ptr = Owner+1.
REQ-027 Without ARB_LOCK_EN, the Lock port and LOCKED state are absent, and behaviour is exactly REQ-012..REQ-020.

Structure
REQ-028 The shared package arb_pkg holds the state enum (IDLE, GRANT, LOCKED) and the default constants N_REQ_DEF=4 and WIDTH_DEF=32.
REQ-029 The round-robin winner search is sub-module rr_priority_pick: combinational, with inputs request vector and Ptr and outputs winner index and any-valid.
REQ-030 The shared storage is the existing 32-bit enabled register, with enable = winner-valid.

Verification
REQ-031 Reset low at t=0, then Req=4'b0000 for 5 cycles -> Data_Out=0, Grant=0, Valid=0 throughout.
REQ-032 Req=4'b1111 held with Data_In[i]=32'hA0+i -> Grant sequence 0001, 0010, 0100, 1000, 0001; Data_Out sequence A0, A1, A2, A3, A0.
REQ-033 Req[2] alone held for 4 cycles with data 32'h32 -> Grant[2] alternates 1,0,1,0; Data_Out=32'h32; Owner=2.
REQ-034 Reset pulsed low for 2 time units while Grant=0100 -> all outputs 0 immediately; next Req=4'b0110 grants requester 1 first.
REQ-035 With ARB_LOCK_EN: requester 1 holds Lock and Req for 3 cycles with data AC, 50, 20 while Req[3] is high -> Grant=0010 for 3 cycles, Data_Out AC, 50, 20; after Lock drops, requester 3 is granted.
REQ-036 Without ARB_LOCK_EN, rerunning REQ-032 gives identical results and no Lock port elaborates.
